// File: rtl/arm_homing_sequencer_if.sv
// Arm register bus as seen by a bus master (sequencer) and the arbiter/peripheral side.
interface arm_homing_sequencer_if;
    logic        bus_req;
    logic        bus_gnt;
    logic [7:0]  register_addr;
    logic        rw;
    logic        select;
    logic [31:0] wdata;
    logic [31:0] rdata;

    modport master (
        output bus_req, register_addr, rw, select, wdata,
        input  bus_gnt, rdata
    );

    modport slave (
        input  bus_req, register_addr, rw, select, wdata,
        output bus_gnt, rdata
    );
endinterface

// File: rtl/arm_homing_sequencer.sv
// Homing sequencer for one arm axis: seek to the limit switch, halt, back off, report result.
// Each register access is a 5-cycle bus transaction issued once the arbiter grants the bus.
module arm_homing_sequencer #(
    parameter logic [7:0]  AXIS_HADDR     = 8'h00,
    parameter logic        HOME_DIR       = 1'b0,
    parameter logic [2:0]  MICROSTEP      = 3'd0,
    parameter logic [31:0] SEEK_DIV       = 32'd12000,
    parameter logic [31:0] MAX_SEEK_STEPS = 32'd20000,
    parameter logic [31:0] BACKOFF_STEPS  = 32'd200,
    parameter logic [15:0] POLL_CYCLES    = 16'd1200
) (
    input  logic                          clk_12MHz,
    input  logic                          reset,
    input  logic                          start,
    input  logic                          abort,
    arm_homing_sequencer_if.master        bus,
    output logic                          busy,
    output logic                          done,
    output logic [1:0]                    error_code
);

    localparam logic [3:0] StIdle    = 4'd0;
    localparam logic [3:0] StSDiv    = 4'd1;
    localparam logic [3:0] StSSteps  = 4'd2;
    localparam logic [3:0] StSGo     = 4'd3;
    localparam logic [3:0] StSWait   = 4'd4;
    localparam logic [3:0] StSRead   = 4'd5;
    localparam logic [3:0] StSHalt   = 4'd6;
    localparam logic [3:0] StBSteps  = 4'd7;
    localparam logic [3:0] StBGo     = 4'd8;
    localparam logic [3:0] StBWait   = 4'd9;
    localparam logic [3:0] StBRead   = 4'd10;
    localparam logic [3:0] StStop    = 4'd11;
    localparam logic [3:0] StFin     = 4'd12;

    localparam logic [2:0] PhArb     = 3'd0;
    localparam logic [2:0] PhSetup   = 3'd1;
    localparam logic [2:0] PhStb1    = 3'd2;
    localparam logic [2:0] PhStb2    = 3'd3;
    localparam logic [2:0] PhStb3    = 3'd4;
    localparam logic [2:0] PhRel     = 3'd5;

    logic [3:0]  state_q, state_d;
    logic [2:0]  phase_q, phase_d;
    logic [15:0] poll_q, poll_d;
    logic [1:0]  err_q, err_d;
    logic        abort_q, abort_d;
    logic        dir_q, dir_d;
    logic [2:0]  status_q, status_d;

    logic        abort_pend;
    logic        stop_req;
    logic [1:0]  stop_err;
    logic        unused_rdata;

    assign unused_rdata = ^bus.rdata[31:3];

    function automatic logic [31:0] ctrl_word(input logic go, input logic dir);
        return {24'h0, go, 1'b0, dir, 1'b0, 1'b1, MICROSTEP};
    endfunction

    assign busy        = (state_q != StIdle) && (state_q != StFin);
    assign done        = (state_q == StFin);
    assign error_code  = err_q;
    assign bus.bus_req = busy;
    assign bus.select  = (phase_q == PhStb1) || (phase_q == PhStb2) || (phase_q == PhStb3);

    always_comb begin
        bus.register_addr = 8'h00;
        bus.rw            = 1'b0;
        bus.wdata         = 32'h0;
        case (state_q)
            StSDiv: begin
                bus.register_addr = AXIS_HADDR + 8'd2;
                bus.wdata         = SEEK_DIV;
            end
            StSSteps: begin
                bus.register_addr = AXIS_HADDR + 8'd3;
                bus.wdata         = MAX_SEEK_STEPS;
            end
            StBSteps: begin
                bus.register_addr = AXIS_HADDR + 8'd3;
                bus.wdata         = BACKOFF_STEPS;
            end
            StSGo, StBGo: begin
                bus.register_addr = AXIS_HADDR;
                bus.wdata         = ctrl_word(1'b1, dir_q);
            end
            StSHalt, StStop: begin
                bus.register_addr = AXIS_HADDR;
                bus.wdata         = ctrl_word(1'b0, dir_q);
            end
            StSRead, StBRead: begin
                bus.register_addr = AXIS_HADDR + 8'd1;
                bus.rw            = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        poll_d     = poll_q;
        err_d      = err_q;
        dir_d      = dir_q;
        status_d   = status_q;
        stop_req   = 1'b0;
        stop_err   = 2'd0;
        // A stop already in progress cannot be aborted again.
        abort_pend = (abort_q | abort) && (state_q != StStop);
        abort_d    = abort_q | (abort && busy && (state_q != StStop));

        case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StSDiv;
                    phase_d = PhArb;
                    err_d   = 2'd0;
                    abort_d = 1'b0;
                    dir_d   = HOME_DIR;
                end
            end
            StSWait, StBWait: begin
                if (abort_pend) begin
                    stop_req = 1'b1;
                    stop_err = 2'd3;
                end else if (poll_q <= 16'd1) begin
                    poll_d  = 16'd0;
                    state_d = (state_q == StSWait) ? StSRead : StBRead;
                end else begin
                    poll_d = poll_q - 16'd1;
                end
            end
            StFin: state_d = StIdle;
            default: begin
                if (phase_q == PhArb) begin
                    if (abort_pend) begin
                        stop_req = 1'b1;
                        stop_err = 2'd3;
                    end else if (bus.bus_gnt) begin
                        phase_d = PhSetup;
                    end
                end else if (phase_q != PhRel) begin
                    phase_d = phase_q + 3'd1;
                    if (phase_q == PhStb3) status_d = bus.rdata[2:0];
                end else begin
                    phase_d = PhArb;
                    if (abort_pend) begin
                        stop_req = 1'b1;
                        stop_err = 2'd3;
                    end else begin
                        // status_q: [0] stepping, [1] fault, [2] limit
                        case (state_q)
                            StSDiv:   state_d = StSSteps;
                            StSSteps: state_d = StSGo;
                            StSGo: begin
                                state_d = StSWait;
                                poll_d  = POLL_CYCLES;
                            end
                            StSRead: begin
                                if (status_q[1]) begin
                                    stop_req = 1'b1;
                                    stop_err = 2'd1;
                                end else if (status_q[2]) begin
                                    state_d = StSHalt;
                                end else if (!status_q[0]) begin
                                    stop_req = 1'b1;
                                    stop_err = 2'd2;
                                end else begin
                                    state_d = StSWait;
                                    poll_d  = POLL_CYCLES;
                                end
                            end
                            StSHalt:  state_d = StBSteps;
                            StBSteps: begin
                                state_d = StBGo;
                                dir_d   = ~HOME_DIR;
                            end
                            StBGo: begin
                                state_d = StBWait;
                                poll_d  = POLL_CYCLES;
                            end
                            StBRead: begin
                                if (status_q[1]) begin
                                    stop_req = 1'b1;
                                    stop_err = 2'd1;
                                end else if (status_q[0]) begin
                                    state_d = StBWait;
                                    poll_d  = POLL_CYCLES;
                                end else if (status_q[2]) begin
                                    stop_req = 1'b1;
                                    stop_err = 2'd2;
                                end else begin
                                    state_d = StFin;
                                end
                            end
                            StStop:   state_d = StFin;
                            default:  state_d = StIdle;
                        endcase
                    end
                end
            end
        endcase

        if (stop_req) begin
            state_d = StStop;
            phase_d = PhArb;
            err_d   = stop_err;
            abort_d = 1'b0;
        end
    end

    always_ff @(posedge clk_12MHz) begin
        if (reset) begin
            state_q  <= StIdle;
            phase_q  <= PhArb;
            poll_q   <= 16'd0;
            err_q    <= 2'd0;
            abort_q  <= 1'b0;
            dir_q    <= 1'b0;
            status_q <= 3'd0;
        end else begin
            state_q  <= state_d;
            phase_q  <= phase_d;
            poll_q   <= poll_d;
            err_q    <= err_d;
            abort_q  <= abort_d;
            dir_q    <= dir_d;
            status_q <= status_d;
        end
    end

endmodule

// File: tb/tb_arm_homing_sequencer.sv
// Bench for arm_homing_sequencer: behavioural axis peripheral, write scoreboard, scenario table.
module tb_arm_homing_sequencer;

    localparam logic [7:0]  HADDR      = 8'h40;
    localparam logic        HOME_DIR   = 1'b0;
    localparam logic [2:0]  MICROSTEP  = 3'd2;
    localparam logic [31:0] SEEK_DIV   = 32'd12000;
    localparam logic [31:0] MAX_STEPS  = 32'd100;
    localparam logic [31:0] BACK_STEPS = 32'd40;
    localparam logic [15:0] POLL       = 16'd4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic       busy, done;
    logic [1:0] error_code;

    arm_homing_sequencer_if bus_if ();

    arm_homing_sequencer #(
        .AXIS_HADDR     (HADDR),
        .HOME_DIR       (HOME_DIR),
        .MICROSTEP      (MICROSTEP),
        .SEEK_DIV       (SEEK_DIV),
        .MAX_SEEK_STEPS (MAX_STEPS),
        .BACKOFF_STEPS  (BACK_STEPS),
        .POLL_CYCLES    (POLL)
    ) dut (
        .clk_12MHz  (clk),
        .reset      (reset),
        .start      (start),
        .abort      (abort),
        .bus        (bus_if),
        .busy       (busy),
        .done       (done),
        .error_code (error_code)
    );

    always #5 clk = ~clk;

    // Axis peripheral model: position relative to the switch, limit when pos <= 0.
    int   cfg_pos0 = 0;
    int   cfg_fault_rd = 0;
    logic model_clr = 1'b0;
    logic m_go, m_dir, m_fault, m_sel_prev;
    int   m_steps, m_pos, m_rd_cnt;
    logic m_stepping, m_limit;
    logic [7:0] m_off;

    assign m_stepping   = m_go && (m_steps > 0);
    assign m_limit      = (m_pos <= 0);
    assign m_off        = bus_if.register_addr - HADDR;
    assign bus_if.rdata = {29'b0, m_limit, m_fault, m_stepping};

    always @(posedge clk) begin
        if (reset || model_clr) begin
            m_go <= 1'b0; m_dir <= 1'b0; m_steps <= 0; m_pos <= cfg_pos0;
            m_fault <= 1'b0; m_rd_cnt <= 0; m_sel_prev <= 1'b0;
        end else begin
            m_sel_prev <= bus_if.select;
            if (m_stepping) begin
                m_steps <= m_steps - 1;
                m_pos   <= (m_dir == HOME_DIR) ? m_pos - 1 : m_pos + 1;
            end
            if (bus_if.select && !m_sel_prev) begin
                if (!bus_if.rw) begin
                    if (m_off == 8'd0) begin
                        m_go  <= bus_if.wdata[7];
                        m_dir <= bus_if.wdata[5];
                    end else if (m_off == 8'd3) begin
                        m_steps <= int'(bus_if.wdata);
                    end
                end else begin
                    m_rd_cnt <= m_rd_cnt + 1;
                    if (m_rd_cnt + 1 == cfg_fault_rd) m_fault <= 1'b1;
                end
            end
        end
    end

    typedef struct {
        int         pos0;
        int         fault_rd;
        int         abort_wr;
        bit         abort_late;
        bit         abort_with_start;
        int         restart_wr;
        logic [1:0] exp_err;
        int         n_pre;
        bit         add_stop;
    } vec_t;

    int          n_checks = 0;
    int          n_fail = 0;
    int          wr_cnt = 0;
    logic [39:0] exp_q[$];
    logic [39:0] full_wr[6];
    logic [39:0] stop_wr;
    vec_t        vecs[6];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    task automatic monitor();
        logic        sel_prev = 1'b0;
        logic [39:0] e;
        forever begin
            @(negedge clk);
            if (bus_if.select && !sel_prev) begin
                if (!bus_if.rw) begin
                    wr_cnt++;
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, required none",
                                 bus_if.register_addr, bus_if.wdata);
                    end else begin
                        e = exp_q.pop_front();
                        check("bus_write", 64'({bus_if.register_addr, bus_if.wdata}), 64'(e));
                    end
                end else begin
                    check("read_addr", 64'(bus_if.register_addr), 64'(HADDR + 8'd1));
                end
            end
            sel_prev = bus_if.select;
        end
    endtask

    task automatic prep(input int pos0, input int fault_rd, input int n_pre, input bit add_stop);
        cfg_pos0     = pos0;
        cfg_fault_rd = fault_rd;
        model_clr    = 1'b1;
        @(negedge clk);
        model_clr    = 1'b0;
        exp_q.delete();
        for (int i = 0; i < n_pre; i++) exp_q.push_back(full_wr[i]);
        if (add_stop) exp_q.push_back(stop_wr);
    endtask

    task automatic end_checks(input string tag, input logic [1:0] exp_err);
        check({tag, "_err"}, 64'(error_code), 64'(exp_err));
        check({tag, "_busy_at_done"}, 64'(busy), 64'd0);
        check({tag, "_req_at_done"}, 64'(bus_if.bus_req), 64'd0);
        check({tag, "_writes_left"}, 64'(exp_q.size()), 64'd0);
        @(negedge clk);
        check({tag, "_done_pulse"}, 64'(done), 64'd0);
        check({tag, "_req_after"}, 64'(bus_if.bus_req), 64'd0);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        repeat (2) @(negedge clk);
        check({tag, "_err_held"}, 64'(error_code), 64'(exp_err));
        check({tag, "_idle"}, 64'({busy, bus_if.select}), 64'd0);
        exp_q.delete();
    endtask

    task automatic wait_done(input string tag, output bit got);
        got = 1'b0;
        for (int c = 0; c < 5000 && !got; c++) begin
            if (done) got = 1'b1;
            else @(negedge clk);
        end
        check({tag, "_done_seen"}, 64'(got), 64'd1);
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int base;
        int late;
        bit fired;
        bit rs;
        bit got;
        prep(v.pos0, v.fault_rd, v.n_pre, v.add_stop);
        base  = wr_cnt;
        late  = 0;
        fired = 1'b0;
        rs    = 1'b0;
        got   = 1'b0;
        start = 1'b1;
        abort = v.abort_with_start;
        @(negedge clk);
        for (int c = 0; c < 5000 && !got; c++) begin
            start = 1'b0;
            abort = 1'b0;
            if (done) begin
                got = 1'b1;
            end else begin
                if (v.abort_wr > 0 && !fired && (wr_cnt - base) == v.abort_wr) begin
                    if (!v.abort_late && bus_if.select) begin
                        abort = 1'b1;
                        fired = 1'b1;
                    end
                    if (v.abort_late && !bus_if.select) begin
                        late++;
                        if (late == 2) begin
                            abort = 1'b1;
                            fired = 1'b1;
                        end
                    end
                end
                if (v.restart_wr > 0 && !rs && (wr_cnt - base) == v.restart_wr) begin
                    start = 1'b1;
                    rs    = 1'b1;
                end
                @(negedge clk);
            end
        end
        check({tag, "_done_seen"}, 64'(got), 64'd1);
        if (got) end_checks(tag, v.exp_err);
    endtask

    initial begin
        bit got;
        bit sel_seen;
        int base;
        bus_if.bus_gnt = 1'b1;

        full_wr[0] = {HADDR + 8'd2, SEEK_DIV};
        full_wr[1] = {HADDR + 8'd3, MAX_STEPS};
        full_wr[2] = {HADDR, 32'h0000_008A};
        full_wr[3] = {HADDR, 32'h0000_000A};
        full_wr[4] = {HADDR + 8'd3, BACK_STEPS};
        full_wr[5] = {HADDR, 32'h0000_00AA};
        stop_wr    = {HADDR, 32'h0000_000A};

        //         pos0   flt ab_wr late w/start rst err   pre stop
        vecs[0] = '{50,    0,  0,    0,   1,      0,  2'd0, 6,  0};
        vecs[1] = '{10000, 0,  0,    0,   0,      0,  2'd2, 3,  1};
        vecs[2] = '{10000, 3,  0,    0,   0,      0,  2'd1, 3,  1};
        vecs[3] = '{10000, 0,  3,    1,   0,      0,  2'd3, 3,  1};
        vecs[4] = '{0,     0,  0,    0,   0,      4,  2'd0, 6,  0};
        vecs[5] = '{10000, 0,  1,    0,   0,      0,  2'd3, 1,  1};

        fork
            monitor();
        join_none

        repeat (3) @(negedge clk);
        check("reset_outputs", 64'({busy, done, bus_if.bus_req, bus_if.select, bus_if.rw,
                                    error_code, bus_if.register_addr, bus_if.wdata}), 64'd0);
        reset = 1'b0;
        @(negedge clk);
        check("idle_outputs", 64'({busy, done, bus_if.bus_req, bus_if.select, bus_if.rw,
                                   error_code, bus_if.register_addr, bus_if.wdata}), 64'd0);

        for (int i = 0; i < 6; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        // Grant withheld after start: request stays up, no strobe until granted.
        prep(50, 0, 6, 1'b0);
        bus_if.bus_gnt = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        sel_seen = 1'b0;
        for (int c = 0; c < 100; c++) begin
            if (bus_if.select) sel_seen = 1'b1;
            @(negedge clk);
        end
        check("nognt_no_select", 64'(sel_seen), 64'd0);
        check("nognt_req", 64'({bus_if.bus_req, busy}), 64'h3);
        bus_if.bus_gnt = 1'b1;
        @(negedge clk);
        check("gnt_setup", 64'({bus_if.select, bus_if.rw, bus_if.register_addr}),
              64'({1'b0, 1'b0, HADDR + 8'd2}));
        @(negedge clk);
        check("gnt_strobe", 64'(bus_if.select), 64'd1);
        wait_done("gnt", got);
        if (got) end_checks("gnt", 2'd0);

        // Reset during the strobe of the seek-go control write.
        prep(50, 0, 3, 1'b0);
        base  = wr_cnt;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        got   = 1'b0;
        for (int c = 0; c < 2000 && !got; c++) begin
            if ((wr_cnt - base) == 3 && bus_if.select) got = 1'b1;
            else @(negedge clk);
        end
        check("rst_mid_reached", 64'(got), 64'd1);
        reset = 1'b1;
        @(negedge clk);
        check("rst_mid_outputs", 64'({bus_if.select, busy, bus_if.bus_req, done}), 64'd0);
        reset = 1'b0;
        @(negedge clk);
        check("rst_mid_writes_left", 64'(exp_q.size()), 64'd0);
        check("rst_mid_idle", 64'({bus_if.select, busy, bus_if.bus_req, error_code}), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
